// File: rtl/sprite_plotter.sv
// Sprite/clear-screen plotter feeding the VGA adapter one pixel per clock.
// Build option SPRITE_MASK_EN: when defined the per-pixel mask is honoured, otherwise sprites draw solid.
`timescale 1ns/1ps
module sprite_plotter #(
  parameter int SPR_W = 4,
  parameter int SPR_H = 4,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int CW    = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_draw,
  input  logic                   req_clear,
  input  logic [XW-1:0]          base_x,
  input  logic [YW-1:0]          base_y,
  input  logic [CW-1:0]          colour_in,
  input  logic [SPR_W*SPR_H-1:0] mask,
  output logic [XW-1:0]          x,
  output logic [YW-1:0]          y,
  output logic [CW-1:0]          colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  localparam int N = SPR_W * SPR_H;
`ifdef SPRITE_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRAW, CLEAR, DONE} state_t;

  state_t        state, state_d;
  logic [XW-1:0] col, col_d;
  logic [YW-1:0] row, row_d;
  logic [XW-1:0] bx_q, bx_d;
  logic [YW-1:0] by_q, by_d;
  logic [CW-1:0] colour_q, colour_q_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic [CW-1:0] colour_d;
  logic          plot_d, busy_d, done_d;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;

  // One extra bit on the sums so coordinates past the screen edge clip instead of wrapping.
  function automatic logic on_screen(input logic [XW:0] sx, input logic [YW:0] sy);
    return (sx < (XW+1)'(SCR_W)) && (sy < (YW+1)'(SCR_H));
  endfunction

  assign sum_x = {1'b0, bx_q} + {1'b0, col};
  assign sum_y = {1'b0, by_q} + {1'b0, row};

  always_comb begin
    state_d    = state;
    col_d      = col;
    row_d      = row;
    bx_d       = bx_q;
    by_d       = by_q;
    colour_q_d = colour_q;
    mask_d     = mask_q;
    x_d        = x;
    y_d        = y;
    colour_d   = colour;
    plot_d     = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (req_clear) begin
          state_d = CLEAR;
          col_d   = '0;
          row_d   = '0;
          busy_d  = 1'b1;
        end else if (req_draw) begin
          state_d    = DRAW;
          col_d      = '0;
          row_d      = '0;
          bx_d       = base_x;
          by_d       = base_y;
          colour_q_d = colour_in;
          mask_d     = mask;
          busy_d     = 1'b1;
        end
      end
      DRAW: begin
        x_d      = sum_x[XW-1:0];
        y_d      = sum_y[YW-1:0];
        colour_d = colour_q;
        // Mask is consumed LSB-first, matching the row-major scan order.
        plot_d   = on_screen(sum_x, sum_y) & (mask_q[0] | !MASK_EN);
        mask_d   = mask_q >> 1;
        if (col == XW'(SPR_W-1)) begin
          col_d = '0;
          if (row == YW'(SPR_H-1)) state_d = DONE;
          else                     row_d   = row + YW'(1);
        end else begin
          col_d = col + XW'(1);
        end
      end
      CLEAR: begin
        x_d      = col;
        y_d      = row;
        colour_d = '0;
        plot_d   = 1'b1;
        if (col == XW'(SCR_W-1)) begin
          col_d = '0;
          if (row == YW'(SCR_H-1)) state_d = DONE;
          else                     row_d   = row + YW'(1);
        end else begin
          col_d = col + XW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      colour_q <= '0;
      mask_q   <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      col      <= col_d;
      row      <= row_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      colour_q <= colour_q_d;
      mask_q   <= mask_d;
      x        <= x_d;
      y        <= y_d;
      colour   <= colour_d;
      plot     <= plot_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: stimulus queues expected pixels/done pulses, a monitor checks them.
`timescale 1ns/1ps
module tb_sprite_plotter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_draw = 1'b0;
  logic        req_clear = 1'b0;
  logic [7:0]  base_x = '0;
  logic [6:0]  base_y = '0;
  logic [2:0]  colour_in = '0;
  logic [15:0] mask = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  sprite_plotter #(
    .SPR_W(4), .SPR_H(4), .SCR_W(160), .SCR_H(120), .XW(8), .YW(7), .CW(3)
  ) dut (
    .clk(clk), .resetn(resetn), .req_draw(req_draw), .req_clear(req_clear),
    .base_x(base_x), .base_y(base_y), .colour_in(colour_in), .mask(mask),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } px_t;

  px_t exp_q[$];
  int  done_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  plot_cnt = 0;
  int  last_x = -1;
  int  last_y = -1;
  px_t e;
  int  de;

  // Monitor: every plot strobe and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      plot_cnt++;
      last_x = int'(x);
      last_y = int'(y);
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_plot cyc=%0d x=%0d y=%0d colour=%0d required=no plot", cyc, x, y, colour);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc !== cyc || e.x !== x || e.y !== y || e.c !== colour) begin
          n_fail++;
          $display("FAIL pixel actual cyc=%0d (%0d,%0d) c=%0d required cyc=%0d (%0d,%0d) c=%0d",
                   cyc, x, y, colour, e.cyc, e.x, e.y, e.c);
        end
      end
    end
    if (done === 1'b1) begin
      n_chk++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done cyc=%0d required=no done", cyc);
      end else begin
        de = done_q.pop_front();
        if (de !== cyc) begin
          n_fail++;
          $display("FAIL done_cycle actual=%0d required=%0d", cyc, de);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_px(input int c, input int px, input int py, input int col);
    px_t p;
    p.cyc = c;
    p.x   = 8'(px);
    p.y   = 7'(py);
    p.c   = 3'(col);
    exp_q.push_back(p);
  endtask

  // Solid 4x4 sprite accepted at c0: pixel k appears k+1 cycles later, off-screen pixels skipped.
  task automatic push_rect(input int c0, input int bx, input int by, input int col);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (bx + c < 160 && by + r < 120) push_px(c0 + r*4 + c + 1, bx + c, by + r, col);
  endtask

  task automatic start_draw(input int bx, input int by, input int col, input logic [15:0] m,
                            output int c0);
    base_x    = 8'(bx);
    base_y    = 7'(by);
    colour_in = 3'(col);
    mask      = m;
    req_draw  = 1'b1;
    tick();
    req_draw  = 1'b0;
    c0        = cyc;
  endtask

  task automatic wait_idle(input string name, input int c_end);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 25000) begin
      n++;
      tick();
    end
    check({name, "_busy_end"}, cyc, c_end);
    check({name, "_pix_left"}, exp_q.size(), 0);
    check({name, "_done_left"}, done_q.size(), 0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_x"}, x, 0);
    check({name, "_y"}, y, 0);
    check({name, "_colour"}, colour, 0);
    check({name, "_plot"}, plot, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d required=completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, pc;

    tick();
    tick();
    check_zero("reset");
    resetn = 1'b1;
    tick();

    // Solid draw
    pc = plot_cnt;
    start_draw(10, 20, 5, 16'hFFFF, c0);
    push_rect(c0, 10, 20, 5);
    done_q.push_back(c0 + 17);
    wait_idle("solid", c0 + 18);
    check("solid_plots", plot_cnt - pc, 16);

    // Masked draw: only first and last pixel enabled
    pc = plot_cnt;
    start_draw(40, 50, 2, 16'h8001, c0);
`ifdef SPRITE_MASK_EN
    push_px(c0 + 1, 40, 50, 2);
    push_px(c0 + 16, 43, 53, 2);
`else
    push_rect(c0, 40, 50, 2);
`endif
    done_q.push_back(c0 + 17);
    wait_idle("masked", c0 + 18);
`ifdef SPRITE_MASK_EN
    check("masked_plots", plot_cnt - pc, 2);
`else
    check("masked_plots", plot_cnt - pc, 16);
`endif

    // Clipping at the bottom-right corner
    pc = plot_cnt;
    start_draw(158, 118, 7, 16'hFFFF, c0);
    push_px(c0 + 1, 158, 118, 7);
    push_px(c0 + 2, 159, 118, 7);
    push_px(c0 + 5, 158, 119, 7);
    push_px(c0 + 6, 159, 119, 7);
    done_q.push_back(c0 + 17);
    wait_idle("clip", c0 + 18);
    check("clip_plots", plot_cnt - pc, 4);

    // Reset in the middle of a draw
    start_draw(30, 40, 1, 16'hFFFF, c0);
    push_px(c0 + 1, 30, 40, 1);
    push_px(c0 + 2, 31, 40, 1);
    push_px(c0 + 3, 32, 40, 1);
    tick();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    check_zero("midreset1");
    tick();
    check_zero("midreset2");
    resetn = 1'b1;
    tick();
    tick();
    check_zero("post_reset");
    check("midreset_pix_left", exp_q.size(), 0);
    start_draw(30, 40, 1, 16'hFFFF, c0);
    push_rect(c0, 30, 40, 1);
    done_q.push_back(c0 + 17);
    wait_idle("after_reset", c0 + 18);

    // Request pulsed while busy is ignored
    pc = plot_cnt;
    start_draw(60, 70, 4, 16'hFFFF, c0);
    push_rect(c0, 60, 70, 4);
    done_q.push_back(c0 + 17);
    tick();
    tick();
    base_x   = 8'd0;
    base_y   = 7'd0;
    req_draw = 1'b1;
    tick();
    req_draw = 1'b0;
    wait_idle("busy_pulse", c0 + 18);
    check("busy_pulse_plots", plot_cnt - pc, 16);

    // Request held through DONE starts a second draw on the following IDLE cycle
    pc = plot_cnt;
    start_draw(80, 90, 6, 16'hFFFF, c0);
    req_draw = 1'b1;
    c1 = c0 + 18;
    push_rect(c0, 80, 90, 6);
    done_q.push_back(c0 + 17);
    push_rect(c1, 80, 90, 6);
    done_q.push_back(c1 + 17);
    for (int i = 0; i < 18; i++) tick();
    req_draw = 1'b0;
    check("held_busy_mid", busy, 1);
    wait_idle("held", c1 + 18);
    check("held_plots", plot_cnt - pc, 32);

    // Clear wins over a simultaneous draw request
    pc = plot_cnt;
    base_x    = 8'd5;
    base_y    = 7'd5;
    colour_in = 3'd7;
    req_clear = 1'b1;
    req_draw  = 1'b1;
    tick();
    req_clear = 1'b0;
    req_draw  = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 19200; k++) push_px(c0 + k + 1, k % 160, k / 160, 0);
    done_q.push_back(c0 + 19201);
    wait_idle("clear", c0 + 19202);
    check("clear_plots", plot_cnt - pc, 19200);
    check("clear_last_x", last_x, 159);
    check("clear_last_y", last_y, 119);
    tick();
    tick();
    check("dropped_draw_busy", busy, 0);
    check("dropped_draw_plots", plot_cnt - pc, 19200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
